// File: rtl/cpu_param_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_param_pkg
//  Description : Shared definitions for the parametrised multi-cycle core:
//                opcode values, the execute/memory state encoding and the
//                ALU operation encoding used between cpu_param and alu_param.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_param_pkg;

   // Opcode byte, INSTRUCTION[31:24]
   localparam logic [7:0] OP_LOADI = 8'h00;
   localparam logic [7:0] OP_MOV   = 8'h01;
   localparam logic [7:0] OP_ADD   = 8'h02;
   localparam logic [7:0] OP_SUB   = 8'h03;
   localparam logic [7:0] OP_AND   = 8'h04;
   localparam logic [7:0] OP_OR    = 8'h05;
   localparam logic [7:0] OP_J     = 8'h06;
   localparam logic [7:0] OP_BEQ   = 8'h07;
   localparam logic [7:0] OP_BNE   = 8'h08;
   localparam logic [7:0] OP_SLL   = 8'h09;
   localparam logic [7:0] OP_SRL   = 8'h0A;
   localparam logic [7:0] OP_SRA   = 8'h0B;
   localparam logic [7:0] OP_ROR   = 8'h0C;
   localparam logic [7:0] OP_LWD   = 8'h0D;
   localparam logic [7:0] OP_LWI   = 8'h0E;
   localparam logic [7:0] OP_SWD   = 8'h0F;
   localparam logic [7:0] OP_SWI   = 8'h10;

   typedef enum logic [0:0] {
      S_EXEC = 1'b0,
      S_MEM  = 1'b1
   } state_t;

   typedef enum logic [3:0] {
      ALU_PASS = 4'd0,
      ALU_ADD  = 4'd1,
      ALU_SUB  = 4'd2,
      ALU_AND  = 4'd3,
      ALU_OR   = 4'd4,
      ALU_SLL  = 4'd5,
      ALU_SRL  = 4'd6,
      ALU_SRA  = 4'd7,
      ALU_ROR  = 4'd8
   } aluop_t;

endpackage : cpu_param_pkg
`default_nettype wire

// File: rtl/alu_param.sv
`default_nettype none
// ============================================================================
//  Module      : alu_param
//  Description : Combinational ALU of DATA_W bits. Pass-through, add, sub,
//                and, or, and four shift/rotate modes driven by an 8-bit
//                shift amount.
//  Ports       : DATA1  - first operand (rs1), also the shifted value
//                DATA2  - second operand (rs2 or immediate), PASS source
//                ALUOP  - operation select
//                SHAMT  - shift/rotate amount (raw immediate byte)
//                RESULT - operation result
//                ZERO   - RESULT is all zeros
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_param
   import cpu_param_pkg::*;
#(
   parameter int DATA_W = 8
) (
   input  logic [DATA_W-1:0] DATA1,
   input  logic [DATA_W-1:0] DATA2,
   input  aluop_t            ALUOP,
   input  logic [7:0]        SHAMT,
   output logic [DATA_W-1:0] RESULT,
   output logic              ZERO
);

   logic        shift_sat;
   logic [31:0] rot_amt;

   // Logical/arithmetic shifts saturate once the amount reaches the width.
   assign shift_sat = ({24'd0, SHAMT} >= 32'(DATA_W));
   // Rotation wraps; a zero amount makes the left term shift out entirely.
   assign rot_amt   = {24'd0, SHAMT} % 32'(DATA_W);

   always_comb begin
      RESULT = DATA2;
      case (ALUOP)
         ALU_PASS: RESULT = DATA2;
         ALU_ADD:  RESULT = DATA1 + DATA2;
         ALU_SUB:  RESULT = DATA1 - DATA2;
         ALU_AND:  RESULT = DATA1 & DATA2;
         ALU_OR:   RESULT = DATA1 | DATA2;
         ALU_SLL:  RESULT = shift_sat ? '0 : (DATA1 << SHAMT);
         ALU_SRL:  RESULT = shift_sat ? '0 : (DATA1 >> SHAMT);
         ALU_SRA:  RESULT = shift_sat ? {DATA_W{DATA1[DATA_W-1]}}
                                      : $unsigned($signed(DATA1) >>> SHAMT);
         ALU_ROR:  RESULT = (DATA1 >> rot_amt) | (DATA1 << (32'(DATA_W) - rot_amt));
         default:  RESULT = DATA2;
      endcase
   end

   assign ZERO = (RESULT == '0);

endmodule : alu_param
`default_nettype wire

// File: rtl/cpu_param.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_param
//  Description : Parametrised multi-cycle core. ALU, branch and jump
//                instructions commit in one cycle in S_EXEC; loads and stores
//                latch a registered request and wait in S_MEM until the
//                memory drops MEM_BUSYWAIT.
//  Ports       : CLK           - clock, rising edge
//                RESET         - synchronous active-high reset
//                INSTRUCTION   - instruction at PC (combinational)
//                PC            - current instruction address
//                MEM_READ      - registered load request
//                MEM_WRITE     - registered store request
//                MEM_ADDRESS   - registered access address
//                MEM_WRITEDATA - registered store data
//                MEM_READDATA  - load data, valid when not busy in S_MEM
//                MEM_BUSYWAIT  - memory stall, sampled only in S_MEM
//  Revision    : 1.0 - initial release
// ============================================================================
module cpu_param
   import cpu_param_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int REG_N  = 8
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic [31:0]       INSTRUCTION,
   output logic [31:0]       PC,
   output logic              MEM_READ,
   output logic              MEM_WRITE,
   output logic [DATA_W-1:0] MEM_ADDRESS,
   output logic [DATA_W-1:0] MEM_WRITEDATA,
   input  logic [DATA_W-1:0] MEM_READDATA,
   input  logic              MEM_BUSYWAIT
);

   localparam int IDX_W = (REG_N > 1) ? $clog2(REG_N) : 1;

   // ---------------------------------------------------------------- state
   state_t            state_q, state_d;
   logic [31:0]       pc_q, pc_d;
   logic              mem_read_q, mem_read_d;
   logic              mem_write_q, mem_write_d;
   logic [DATA_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic [DATA_W-1:0] regs_q [REG_N];

   // --------------------------------------------------------------- decode
   logic [7:0]        opcode;
   logic [IDX_W-1:0]  rd_idx, rs1_idx, rs2_idx;
   logic [DATA_W-1:0] imm;
   logic [DATA_W-1:0] rs1_val, rs2_val;
   logic [31:0]       pc_plus4, br_target;
   logic              unused_instr_bits;

   assign opcode  = INSTRUCTION[31:24];
   assign rd_idx  = INSTRUCTION[16 +: IDX_W];
   assign rs1_idx = INSTRUCTION[8 +: IDX_W];
   assign rs2_idx = INSTRUCTION[0 +: IDX_W];

   // High index bits of rs1 are ignored by design.
   assign unused_instr_bits = ^INSTRUCTION[15:8];

   // Immediate byte fitted to the datapath: zero-extend or truncate.
   generate
      if (DATA_W > 8) begin : g_imm_zext
         assign imm = {{(DATA_W-8){1'b0}}, INSTRUCTION[7:0]};
      end else if (DATA_W == 8) begin : g_imm_exact
         assign imm = INSTRUCTION[7:0];
      end else begin : g_imm_trunc
         assign imm = INSTRUCTION[DATA_W-1:0];
      end
   endgenerate

   // Combinational read ports: a same-cycle write is seen only after the edge.
   assign rs1_val = regs_q[rs1_idx];
   assign rs2_val = regs_q[rs2_idx];

   assign pc_plus4  = pc_q + 32'd4;
   assign br_target = pc_plus4 + {{22{INSTRUCTION[23]}}, INSTRUCTION[23:16], 2'b00};

   // ------------------------------------------------------------------ ALU
   aluop_t            aluop;
   logic [DATA_W-1:0] alu_data2;
   logic [DATA_W-1:0] alu_result;
   logic              alu_zero;

   alu_param #(
      .DATA_W (DATA_W)
   ) u_alu (
      .DATA1  (rs1_val),
      .DATA2  (alu_data2),
      .ALUOP  (aluop),
      .SHAMT  (INSTRUCTION[7:0]),
      .RESULT (alu_result),
      .ZERO   (alu_zero)
   );

   // ------------------------------------------------ next-state / outputs
   logic              rf_we;
   logic [DATA_W-1:0] rf_wdata;

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      mem_read_d  = mem_read_q;
      mem_write_d = mem_write_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      aluop       = ALU_PASS;
      alu_data2   = rs2_val;
      rf_we       = 1'b0;
      rf_wdata    = alu_result;

      case (state_q)
         S_EXEC: begin
            pc_d = pc_plus4;
            case (opcode)
               OP_LOADI: begin
                  alu_data2 = imm;
                  rf_we     = 1'b1;
               end
               OP_MOV:   rf_we = 1'b1;
               OP_ADD:   begin aluop = ALU_ADD; rf_we = 1'b1; end
               OP_SUB:   begin aluop = ALU_SUB; rf_we = 1'b1; end
               OP_AND:   begin aluop = ALU_AND; rf_we = 1'b1; end
               OP_OR:    begin aluop = ALU_OR;  rf_we = 1'b1; end
               OP_J:     pc_d = br_target;
               OP_BEQ: begin
                  aluop = ALU_SUB;
                  pc_d  = alu_zero ? br_target : pc_plus4;
               end
               OP_BNE: begin
                  aluop = ALU_SUB;
                  pc_d  = alu_zero ? pc_plus4 : br_target;
               end
               OP_SLL:   begin aluop = ALU_SLL; rf_we = 1'b1; end
               OP_SRL:   begin aluop = ALU_SRL; rf_we = 1'b1; end
               OP_SRA:   begin aluop = ALU_SRA; rf_we = 1'b1; end
               OP_ROR:   begin aluop = ALU_ROR; rf_we = 1'b1; end
               OP_LWD, OP_LWI: begin
                  pc_d       = pc_q;
                  mem_read_d = 1'b1;
                  mem_addr_d = (opcode == OP_LWD) ? rs2_val : imm;
                  state_d    = S_MEM;
               end
               OP_SWD, OP_SWI: begin
                  pc_d        = pc_q;
                  mem_write_d = 1'b1;
                  mem_addr_d  = (opcode == OP_SWD) ? rs2_val : imm;
                  mem_wdata_d = rs1_val;
                  state_d     = S_MEM;
               end
               default: ;
            endcase
         end

         S_MEM: begin
            // Request stays asserted and stable until the memory is ready.
            if (!MEM_BUSYWAIT) begin
               rf_we       = mem_read_q;
               rf_wdata    = MEM_READDATA;
               pc_d        = pc_plus4;
               mem_read_d  = 1'b0;
               mem_write_d = 1'b0;
               state_d     = S_EXEC;
            end
         end

         default: state_d = S_EXEC;
      endcase
   end

   // ------------------------------------------------------------ registers
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q     <= S_EXEC;
         pc_q        <= '0;
         mem_read_q  <= 1'b0;
         mem_write_q <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         for (int i = 0; i < REG_N; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         mem_read_q  <= mem_read_d;
         mem_write_q <= mem_write_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         if (rf_we) begin
            regs_q[rd_idx] <= rf_wdata;
         end
      end
   end

   assign PC            = pc_q;
   assign MEM_READ      = mem_read_q;
   assign MEM_WRITE     = mem_write_q;
   assign MEM_ADDRESS   = mem_addr_q;
   assign MEM_WRITEDATA = mem_wdata_q;

endmodule : cpu_param
`default_nettype wire

// File: tb/tb_cpu_param.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cpu_param
//  Description : Self-checking bench for cpu_param. Two instances (8-bit/8
//                registers and 16-bit/16 registers) execute the same
//                instruction stream; each is compared with its own
//                architectural model (register array + PC).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_param;

   logic        clk;
   logic        rst;
   logic [31:0] instr;
   logic        bw;
   logic [15:0] rdata;

   logic [31:0] pc8, pc16;
   logic        mr8, mw8, mr16, mw16;
   logic [7:0]  ma8, mwd8;
   logic [15:0] ma16, mwd16;

   cpu_param #(.DATA_W(8), .REG_N(8)) dut8 (
      .CLK(clk), .RESET(rst), .INSTRUCTION(instr), .PC(pc8),
      .MEM_READ(mr8), .MEM_WRITE(mw8), .MEM_ADDRESS(ma8), .MEM_WRITEDATA(mwd8),
      .MEM_READDATA(rdata[7:0]), .MEM_BUSYWAIT(bw)
   );

   cpu_param #(.DATA_W(16), .REG_N(16)) dut16 (
      .CLK(clk), .RESET(rst), .INSTRUCTION(instr), .PC(pc16),
      .MEM_READ(mr16), .MEM_WRITE(mw16), .MEM_ADDRESS(ma16), .MEM_WRITEDATA(mwd16),
      .MEM_READDATA(rdata), .MEM_BUSYWAIT(bw)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input longint got, input longint exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   // ------------------------------------------------------ reference model
   longint mreg [2][16];
   longint mpc  [2];

   typedef struct {
      bit     we;
      int     rd;
      longint val;
      longint npc;
      bit     mem;
      bit     ld;
      longint addr;
      longint wdat;
   } pred_t;

   function automatic void model_reset();
      for (int k = 0; k < 2; k++) begin
         mpc[k] = 0;
         for (int i = 0; i < 16; i++) mreg[k][i] = 0;
      end
   endfunction

   function automatic pred_t predict(input int k, input logic [31:0] ins, input longint ldv);
      pred_t  p;
      int     w    = (k != 0) ? 16 : 8;
      int     nreg = (k != 0) ? 16 : 8;
      longint mask = (longint'(1) << w) - 1;
      int     op   = int'(ins[31:24]);
      int     rs1  = int'(ins[15:8]) % nreg;
      int     rs2  = int'(ins[7:0]) % nreg;
      longint a    = mreg[k][rs1];
      longint b    = mreg[k][rs2];
      longint imm  = longint'(ins[7:0]) & mask;
      longint off  = longint'(ins[23:16]);
      longint sgn;
      int     r;
      if (off >= 128) off = off - 256;
      p.we   = 0;
      p.rd   = int'(ins[23:16]) % nreg;
      p.val  = 0;
      p.npc  = (mpc[k] + 4) & 64'hFFFF_FFFF;
      p.mem  = 0;
      p.ld   = 0;
      p.addr = 0;
      p.wdat = 0;
      case (op)
         0:  begin p.we = 1; p.val = imm; end
         1:  begin p.we = 1; p.val = b; end
         2:  begin p.we = 1; p.val = (a + b) & mask; end
         3:  begin p.we = 1; p.val = (a - b) & mask; end
         4:  begin p.we = 1; p.val = a & b; end
         5:  begin p.we = 1; p.val = a | b; end
         6:  p.npc = (mpc[k] + 4 + off * 4) & 64'hFFFF_FFFF;
         7:  if (a == b) p.npc = (mpc[k] + 4 + off * 4) & 64'hFFFF_FFFF;
         8:  if (a != b) p.npc = (mpc[k] + 4 + off * 4) & 64'hFFFF_FFFF;
         9:  begin p.we = 1; p.val = (imm >= w) ? 0 : ((a << imm) & mask); end
         10: begin p.we = 1; p.val = (imm >= w) ? 0 : (a >> imm); end
         11: begin
            p.we = 1;
            sgn  = (a >> (w - 1)) & 1;
            if (imm >= w) p.val = (sgn != 0) ? mask : 0;
            else begin
               p.val = a >> imm;
               if (sgn != 0) p.val = p.val | (mask & ~(mask >> imm));
            end
         end
         12: begin
            p.we  = 1;
            r     = int'(imm) % w;
            p.val = ((a >> r) | (a << (w - r))) & mask;
         end
         13: begin p.mem = 1; p.ld = 1; p.we = 1; p.addr = b;   p.val = ldv & mask; end
         14: begin p.mem = 1; p.ld = 1; p.we = 1; p.addr = imm; p.val = ldv & mask; end
         15: begin p.mem = 1; p.addr = b;   p.wdat = a; end
         16: begin p.mem = 1; p.addr = imm; p.wdat = a; end
         default: ;
      endcase
      return p;
   endfunction

   // ---------------------------------------------------------- observers
   function automatic longint got_pc(input int k);
      return (k != 0) ? longint'(pc16) : longint'(pc8);
   endfunction
   function automatic longint got_mr(input int k);
      return (k != 0) ? longint'(mr16) : longint'(mr8);
   endfunction
   function automatic longint got_mw(input int k);
      return (k != 0) ? longint'(mw16) : longint'(mw8);
   endfunction
   function automatic longint got_ma(input int k);
      return (k != 0) ? longint'(ma16) : longint'(ma8);
   endfunction
   function automatic longint got_mwd(input int k);
      return (k != 0) ? longint'(mwd16) : longint'(mwd8);
   endfunction
   function automatic longint got_reg(input int k, input int i);
      logic [3:0] i4;
      i4 = 4'(i);
      return (k != 0) ? longint'(dut16.regs_q[i4]) : longint'(dut8.regs_q[i4[2:0]]);
   endfunction

   function automatic logic [31:0] mk(input logic [7:0] op, input logic [7:0] f2,
                                      input logic [7:0] f1, input logic [7:0] f0);
      return {op, f2, f1, f0};
   endfunction

   // Execute one instruction to completion on both cores and check it.
   task automatic run(input logic [31:0] ins, input int nstall, input logic [15:0] ldv);
      pred_t p [2];
      string sfx;
      for (int k = 0; k < 2; k++) p[k] = predict(k, ins, longint'(ldv));
      instr = ins;
      rdata = ldv;
      bw    = 1'($urandom_range(0, 1));   // irrelevant while executing
      @(posedge clk); #1;
      if (p[0].mem) begin
         for (int c = 0; c <= nstall; c++) begin
            for (int k = 0; k < 2; k++) begin
               sfx = (k != 0) ? "16" : "8";
               check({"req_rd", sfx}, got_mr(k), longint'(p[k].ld));
               check({"req_wr", sfx}, got_mw(k), longint'(!p[k].ld));
               check({"req_addr", sfx}, got_ma(k), p[k].addr);
               if (!p[k].ld) check({"req_wdata", sfx}, got_mwd(k), p[k].wdat);
               check({"pc_hold", sfx}, got_pc(k), mpc[k]);
            end
            bw = (c < nstall);
            @(posedge clk); #1;
         end
      end
      for (int k = 0; k < 2; k++) begin
         sfx = (k != 0) ? "16" : "8";
         check({"pc", sfx}, got_pc(k), p[k].npc);
         check({"rd_idle", sfx}, got_mr(k), 0);
         check({"wr_idle", sfx}, got_mw(k), 0);
         if (p[k].we) begin
            check({"rd_val", sfx}, got_reg(k, p[k].rd), p[k].val);
            mreg[k][p[k].rd] = p[k].val;
         end
         mpc[k] = p[k].npc;
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      model_reset();
   endtask

   // -------------------------------------------------------------- stimulus
   initial begin
      logic [7:0] op;
      int         sel;
      rst   = 1'b1;
      instr = '0;
      bw    = 1'b0;
      rdata = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++) begin
         check("reset_pc", got_pc(k), 0);
         check("reset_mr", got_mr(k), 0);
         check("reset_mw", got_mw(k), 0);
         check("reset_ma", got_ma(k), 0);
         check("reset_mwd", got_mwd(k), 0);
         check("reset_reg", got_reg(k, 3), 0);
      end
      rst = 1'b0;

      // Arithmetic
      run(mk(8'h00, 8'd1, 8'd0, 8'd5), 0, 16'h0);
      run(mk(8'h00, 8'd2, 8'd0, 8'd3), 0, 16'h0);
      run(mk(8'h03, 8'd3, 8'd1, 8'd2), 0, 16'h0);
      run(mk(8'h02, 8'd4, 8'd3, 8'd1), 0, 16'h0);
      check("arith_r3", got_reg(0, 3), 2);
      check("arith_r4", got_reg(0, 4), 7);
      check("arith_pc", got_pc(0), 16);

      // Branches
      do_reset();
      run(mk(8'h00, 8'd1, 8'd0, 8'd9), 0, 16'h0);
      run(mk(8'h00, 8'd2, 8'd0, 8'd9), 0, 16'h0);
      run(mk(8'h07, 8'hFE, 8'd1, 8'd2), 0, 16'h0);
      check("beq_taken_pc", got_pc(0), 4);
      run(mk(8'h08, 8'hFE, 8'd1, 8'd2), 0, 16'h0);
      check("bne_fall_pc", got_pc(0), 8);
      run(mk(8'h06, 8'h01, 8'd0, 8'd0), 0, 16'h0);
      check("j_pc", got_pc(0), 16);

      // Shift saturation and rotation
      run(mk(8'h00, 8'd1, 8'd0, 8'h96), 0, 16'h0);
      run(mk(8'h09, 8'd3, 8'd1, 8'd3), 0, 16'h0);
      run(mk(8'h0A, 8'd4, 8'd1, 8'd9), 0, 16'h0);
      run(mk(8'h0B, 8'd5, 8'd1, 8'd200), 0, 16'h0);
      run(mk(8'h0C, 8'd6, 8'd1, 8'd10), 0, 16'h0);
      check("sll3", got_reg(0, 3), 'hB0);
      check("srl9", got_reg(0, 4), 'h00);
      check("sra200", got_reg(0, 5), 'hFF);
      check("ror10", got_reg(0, 6), 'hA5);

      // Load with three stall cycles
      run(mk(8'h0E, 8'd5, 8'd0, 8'h20), 3, 16'h003C);
      check("lwi_r5", got_reg(0, 5), 'h3C);

      // Zero-wait store
      run(mk(8'h00, 8'd1, 8'd0, 8'h11), 0, 16'h0);
      run(mk(8'h00, 8'd2, 8'd0, 8'h40), 0, 16'h0);
      run(mk(8'h0F, 8'd0, 8'd1, 8'd2), 0, 16'h0);

      // Reset while the store is stalled
      instr = mk(8'h0F, 8'd0, 8'd1, 8'd2);
      bw    = 1'b1;
      @(posedge clk); #1;
      check("abort_req8", got_mw(0), 1);
      @(posedge clk); #1;
      check("abort_stall8", got_mw(0), 1);
      rst = 1'b1;
      @(posedge clk); #1;
      for (int k = 0; k < 2; k++) begin
         check("abort_pc", got_pc(k), 0);
         check("abort_mw", got_mw(k), 0);
         check("abort_ma", got_ma(k), 0);
         check("abort_reg", got_reg(k, 1), 0);
      end
      rst = 1'b0;
      bw  = 1'b0;
      model_reset();

      // Generic width and undefined opcode
      run(mk(8'h00, 8'd15, 8'd0, 8'hFF), 0, 16'h0);
      run(mk(8'h02, 8'd15, 8'd15, 8'd15), 0, 16'h0);
      check("wide_r15", got_reg(1, 15), 'h1FE);
      run(mk(8'h7F, 8'd15, 8'd1, 8'd2), 0, 16'h0);
      check("nop_r15", got_reg(1, 15), 'h1FE);

      // Random instruction stream
      for (int n = 0; n < 400; n++) begin
         sel = int'($urandom_range(0, 19));
         if (sel <= 16) op = 8'(sel);
         else           op = 8'(17 + $urandom_range(0, 200));
         run(mk(op, 8'($urandom), 8'($urandom), 8'($urandom)),
             int'($urandom_range(0, 3)), 16'($urandom));
      end
      for (int k = 0; k < 2; k++) begin
         for (int i = 0; i < ((k != 0) ? 16 : 8); i++) begin
            check($sformatf("final_r%0d_%0d", i, k), got_reg(k, i), mreg[k][i]);
         end
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule : tb_cpu_param
`default_nettype wire
